// File: rtl/adder_arbiter.sv
// Round-robin front end that time-shares one pipelined adder among N_REQ requesters,
// tagging each issued operation so its sum is returned to the requester that sent it.
module adder_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [WIDTH:0]           rsp_c,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_valid,
  input  logic [WIDTH:0]           add_c,
  output logic                     busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DEPTH = ADD_LAT + 1;

  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic                        grant;
  logic [PTR_W-1:0]            gnt_id;
  logic [PTR_W-1:0]            scan_idx;
  int                          scan_sum;

  logic [WIDTH-1:0]            add_a_q, add_a_d;
  logic [WIDTH-1:0]            add_b_q, add_b_d;
  logic [DEPTH-1:0]            tag_vld_q, tag_vld_d;
  logic [DEPTH-1:0][PTR_W-1:0] tag_id_q, tag_id_d;
  logic [N_REQ-1:0]            rsp_valid_q, rsp_valid_d;
  logic [WIDTH:0]              rsp_c_q, rsp_c_d;

  // Arbitration: scan from ptr upward, wrapping modulo N_REQ; first valid requester wins.
  always_comb begin
    grant     = 1'b0;
    gnt_id    = '0;
    req_ready = '0;
    scan_sum  = 0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = int'(ptr_q) + k;
      if (scan_sum >= N_REQ) scan_sum = scan_sum - N_REQ;
      scan_idx = PTR_W'(scan_sum);
      if (!grant && !reset && req_valid[scan_idx]) begin
        grant  = 1'b1;
        gnt_id = scan_idx;
      end
    end
    if (grant) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
  end

  // Issue stage: operands hold when idle so the adder input stays quiet.
  always_comb begin
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    if (grant) begin
      add_a_d = req_a[int'(gnt_id)*WIDTH +: WIDTH];
      add_b_d = req_b[int'(gnt_id)*WIDTH +: WIDTH];
    end
  end

  // Tag stage 0 travels with add_valid; stage ADD_LAT lines up with add_c.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = grant;
    tag_id_d[0]  = gnt_id;
    for (int s = 1; s < DEPTH; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_c_d     = rsp_c_q;
    if (tag_vld_q[ADD_LAT]) begin
      rsp_valid_d[tag_id_q[ADD_LAT]] = 1'b1;
      rsp_c_d                        = add_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_c_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_c_q     <= rsp_c_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_valid = tag_vld_q[0];
  assign busy      = |tag_vld_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_c     = rsp_c_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: a round-robin reference model predicts grants and
// queues expected responses; a monitor pops and compares whenever rsp_valid fires.
module tb_adder_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_a, req_b;
  logic [N-1:0]     req_ready, rsp_valid;
  logic [W:0]       rsp_c;
  logic [W-1:0]     add_a, add_b;
  logic             add_valid, busy;
  logic [W:0]       add_c = '0;

  adder_arbiter #(.N_REQ(N), .WIDTH(W), .ADD_LAT(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_c(rsp_c), .add_a(add_a),
    .add_b(add_b), .add_valid(add_valid), .add_c(add_c), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural one-cycle adder.
  always @(posedge clk) add_c <= {1'b0, add_a} + {1'b0, add_b};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int sum; int cyc; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int rsp_count = 0;
  int m_ptr = 0;
  int last_win = -1;
  int mode = 0;
  logic g1 = 1'b0, g2 = 1'b0;
  logic [W-1:0] ea = '0, eb = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]     = 1'b1;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
  endtask

  // One clock cycle: check at negedge against the model, then update stimulus after posedge.
  task automatic step();
    int win;
    int a, b;
    @(negedge clk);
    win = -1;
    if (reset) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_add_valid", add_valid, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_add_b", add_b, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_c", rsp_c, 0);
      sb.delete();
      m_ptr = 0; g1 = 1'b0; g2 = 1'b0; ea = '0; eb = '0;
    end else begin
      chk("add_valid", add_valid, g1);
      chk("add_a", add_a, ea);
      chk("add_b", add_b, eb);
      chk("busy", busy, g1 | g2);
      for (int k = 0; k < N; k++)
        if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      chk("req_ready", req_ready, (win >= 0) ? (32'd1 << win) : 32'd0);
      g2 = g1;
      g1 = (win >= 0);
      if (win >= 0) begin
        a = int'(req_a[win*W +: W]);
        b = int'(req_b[win*W +: W]);
        ea = W'(a);
        eb = W'(b);
        sb.push_back('{id: win, sum: a + b, cyc: cyc + 3});
        m_ptr = (win + 1) % N;
      end
    end
    last_win = win;
    @(posedge clk);
    #1;
    if (win >= 0) begin
      if (mode == 0) req_valid[win] = 1'b0;
      else if (mode == 2) begin
        if ($urandom_range(1) == 0) req_valid[win] = 1'b0;
        else set_req(win, W'($urandom_range(15)), W'($urandom_range(15)));
      end
    end
    if (mode == 2)
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(3) == 0)
          set_req(i, W'($urandom_range(15)), W'($urandom_range(15)));
  endtask

  // Monitor: every response must match the oldest outstanding operation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid, 32'd1 << e.id);
        chk("rsp_c", rsp_c, e.sum);
        chk("rsp_cycle", cyc, e.cyc);
        rsp_count++;
      end
    end else if (!reset && sb.size() > 0 && sb[0].cyc <= cyc) begin
      chk("rsp_missing", rsp_valid, 32'd1 << sb[0].id);
      void'(sb.pop_front());
    end
  end

  initial begin
    int base;
    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    #1;
    step();
    step();
    reset = 1'b0;

    // Full load from ptr=0: grants 0,1,2,3,0,... with sums 1..4.
    mode = 1;
    for (int i = 0; i < N; i++) set_req(i, W'(i), W'(1));
    step();
    chk("full_first_win", last_win, 0);
    step();
    chk("full_second_win", last_win, 1);
    for (int i = 0; i < 10; i++) step();
    mode = 0;
    req_valid = '0;
    for (int i = 0; i < 4; i++) step();

    // Single request from requester 1: 3 + 5.
    set_req(1, 4'd3, 4'd5);
    step();
    chk("single_add_valid", add_valid, 1);
    chk("single_add_a", add_a, 3);
    chk("single_add_b", add_b, 5);
    step();
    step();
    chk("single_rsp_valid", rsp_valid, 4'b0010);
    chk("single_rsp_c", rsp_c, 8);
    step();
    chk("single_busy_idle", busy, 0);

    // Pointer rotation.
    set_req(2, 4'd1, 4'd1);
    step();
    chk("rot_win2", last_win, 2);
    set_req(0, 4'd2, 4'd2);
    set_req(3, 4'd4, 4'd4);
    step();
    chk("rot_win3", last_win, 3);
    step();
    chk("rot_win0", last_win, 0);
    for (int i = 0; i < 3; i++) step();

    // Carry out and zero sum.
    set_req(1, 4'd15, 4'd15);
    step(); step(); step();
    chk("carry_rsp_c", rsp_c, 30);
    chk("carry_rsp_valid", rsp_valid, 4'b0010);
    set_req(1, 4'd0, 4'd0);
    step(); step(); step();
    chk("zero_rsp_c", rsp_c, 0);
    chk("zero_rsp_valid", rsp_valid, 4'b0010);
    step();

    // Reset mid-flight discards the operation and resets the pointer.
    base = rsp_count;
    set_req(0, 4'd6, 4'd6);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("midrst_no_rsp", rsp_count, base);
    set_req(3, 4'd1, 4'd2);
    set_req(0, 4'd3, 4'd4);
    step();
    chk("midrst_win0", last_win, 0);
    for (int i = 0; i < 5; i++) step();

    // Idle gap: operands hold, one response only.
    base = rsp_count;
    set_req(2, 4'd7, 4'd2);
    step();
    for (int i = 0; i < 5; i++) step();
    chk("idle_add_valid", add_valid, 0);
    chk("idle_add_a", add_a, 7);
    chk("idle_add_b", add_b, 2);
    chk("idle_rsp_count", rsp_count - base, 1);
    chk("idle_rsp_c", rsp_c, 9);

    // Randomized traffic with hold-until-granted requesters.
    mode = 2;
    for (int i = 0; i < 400; i++) step();
    mode = 0;
    req_valid = '0;
    for (int i = 0; i < 6; i++) step();
    chk("drain_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that shares one pipelined `adder` datapath among `N_REQ` requesters. It sits between the requester ports and the adder's `a`/`b`/`valid` inputs. It accepts at most one operand pair per cycle, tracks which requester owns each in-flight operation, and routes the adder's `c` result back to that requester as a one-cycle response pulse. Throughput is one operation per cycle, with no bubbles under continuous load.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 4: operand width; matches the adder's `a`/`b`.
- `ADD_LAT`, 1: cycles from the adder sampling `valid`=1 to the matching `c` being visible at its output.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request.
- `req_a`  in  N_REQ*WIDTH  operand a; slice i belongs to requester i.
- `req_b`  in  N_REQ*WIDTH  operand b; slice i belongs to requester i.
- `req_ready`  out  N_REQ  one-hot grant, combinational.
- `rsp_valid`  out  N_REQ  one-hot response pulse, registered.
- `rsp_c`  out  WIDTH+1  result sum, shared by all requesters and qualified by `rsp_valid`.
- `add_a`  out  WIDTH  drives the adder's `a`.
- `add_b`  out  WIDTH  drives the adder's `b`.
- `add_valid`  out  1  drives the adder's `valid`.
- `add_c`  in  WIDTH+1  adder result.
- `busy`  out  1  high while any operation is in flight.

## Operation
Handshake:
- A transfer occurs in any cycle where `req_valid[i] & req_ready[i]`.
- A requester holds `req_valid` and its operands stable until it is granted.
- `req_ready` is 0 for requesters whose `req_valid` is 0, and is all-zero while `reset` is asserted.

Arbitration:
- Round-robin with a pointer `ptr` of width clog2(N_REQ).
- Search order is `ptr`, `ptr`+1, … modulo N_REQ; the first requester with `req_valid` set wins.
- On a grant to requester i, `ptr` becomes (i+1) mod N_REQ.
- With no grant, `ptr` holds.
- Reset value of `ptr` is 0, so requester 0 has first priority.

Issue stage (registered):
- On a grant, `add_a`/`add_b` load the winner's operand slices and `add_valid` becomes 1 in the next cycle.
- Without a grant, `add_valid` is 0 and `add_a`/`add_b` hold their last values.

Tag pipeline:
- A shift register of depth ADD_LAT+1 carries {valid, requester id} alongside each operation.
- The tag entering the pipeline matches the `add_valid` being issued.
- When the tag emerges aligned with `add_c`, the block captures `rsp_c` ← `add_c` and asserts `rsp_valid[id]` = 1 for exactly one cycle.
- `rsp_c` holds its value when no response is issued.

Arithmetic:
- No truncation: `rsp_c` is the full WIDTH+1-bit sum, with the carry in the MSB.
- Responses return in grant order; there is no reordering.

Busy and reset:
- `busy` is the OR of all valid bits in the issue stage and tag pipeline.
- Reset values: `add_a`=0, `add_b`=0, `add_valid`=0, `rsp_valid`=0, `rsp_c`=0, `busy`=0, `ptr`=0, all tag valid bits 0.
- Reset mid-operation discards every in-flight operation. No `rsp_valid` is ever produced for an operation that was in flight at reset, even if `add_c` changes later.

## Timing
- Grant in cycle T → `add_valid`=1 in T+1 → `add_c` valid in T+1+ADD_LAT → `rsp_valid` in T+2+ADD_LAT. For ADD_LAT=1 this is T+3.
- Back-to-back grants every cycle: a continuous `add_valid` stream and a continuous `rsp_valid` stream, with no stalls.
- Simultaneous events:
  - A new grant and a response retiring in the same cycle are independent; both occur.
  - The same requester may be granted in one cycle and receive an older response in that same cycle.
- Single requester continuously valid: granted every cycle, because `ptr` wraps back to it.
- No backpressure from requesters on responses; every requester must accept `rsp_valid` in any cycle.

## Test plan
- **Reset and single request.** Hold `reset`=1: every output is 0. Release, then in cycle T requester 1 presents a=3, b=5:
  - `req_ready`=4'b0010 in T;
  - `add_valid`=1 with `add_a`=3, `add_b`=5 in T+1;
  - `rsp_valid`=4'b0010 with `rsp_c`=8 in T+3;
  - `busy` is 0 again at T+4.
- **Full load.** All 4 requesters valid continuously with a=i, b=1 → grants in order 0,1,2,3,0,1,… one per cycle; `rsp_valid` follows 3 cycles later in the same order with `rsp_c`=1,2,3,4.
- **Pointer rotation.** Requester 2 is granted, then only requesters 0 and 3 are valid → requester 3 is granted first, then requester 0.
- **Carry.** WIDTH=4 with a=15, b=15 → `rsp_c`=5'b11110 (30). Repeat with a=0, b=0 → `rsp_c`=0, with `rsp_valid` still pulsed.
- **Reset mid-flight.** Grant requester 0 in T, assert `reset` in T+1 and release it in T+2 → `rsp_valid` stays 0 throughout, and `busy` is 0 from reset onward. The next request from requester 3 alongside one from requester 0 → requester 0 wins, because `ptr`=0 after reset.
- **Idle gap.** `req_valid` deasserted for 5 cycles after one operation with a=7, b=2 → `add_valid`=0 while `add_a`=7 and `add_b`=2 hold; exactly one response is produced, with `rsp_c`=9.
